// File: rtl/reg_write_arbiter_if.sv
// Requester/bank bundle for the working-register write-port arbiter.
// Requesters drive req_*; the arbiter returns the grant and the bank write strobe/data.
interface reg_write_arbiter_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned NUM_REG = 8,
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned DATA_W  = 20
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REG-1:0]        wr_en;
   logic [DATA_W-1:0]         wr_data;
   logic                      owner_vld;
   logic                      addr_err;

   modport master (
      output req_valid, req_lock, req_addr, req_data,
      input  gnt, wr_en, wr_data, owner_vld, addr_err
   );

   modport slave (
      input  req_valid, req_lock, req_addr, req_data,
      output gnt, wr_en, wr_data, owner_vld, addr_err
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the write port of the negedge-capture register bank, with an
// optional bounded lock so one requester can issue short back-to-back write bursts.
module reg_write_arbiter #(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned NUM_REG   = 8,
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned DATA_W    = 20,
   parameter int unsigned MAX_BURST = 4
) (
   input logic                clk,
   input logic                rst_n,
   reg_write_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REG-1:0] wr_en_q, wr_en_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic               addr_err_q, addr_err_d;

   logic               grant;
   logic               arb;
   logic [PTR_W-1:0]   win;
   logic [ADDR_W-1:0]  win_addr;
   logic               addr_ok;

   // Arbitration and FSM next state
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      grant       = 1'b0;
      arb         = 1'b0;
      win         = '0;

      unique case (state_q)
         StIdle: arb = 1'b1;
         StOwn: begin
            if (bus.req_valid[owner_q]) begin
               grant       = 1'b1;
               win         = owner_q;
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (!bus.req_lock[owner_q] || (32'(burst_cnt_q) + 1 == MAX_BURST)) begin
                  state_d     = StIdle;
                  burst_cnt_d = '0;
               end
            end else begin
               // Owner went quiet: release and arbitrate in the same cycle.
               state_d     = StIdle;
               burst_cnt_d = '0;
               arb         = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (arb) begin
         for (int k = 0; k < int'(NUM_REQ); k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
            if (!grant && bus.req_valid[idx]) begin
               grant = 1'b1;
               win   = PTR_W'(idx);
            end
         end
         if (grant) begin
            rr_ptr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            if (bus.req_lock[win] && (MAX_BURST > 1)) begin
               state_d     = StOwn;
               owner_d     = win;
               burst_cnt_d = CNT_W'(1);
            end
         end
      end
   end

   assign win_addr = bus.req_addr[32'(win)*ADDR_W +: ADDR_W];
   assign addr_ok  = 32'(win_addr) < NUM_REG;

   // Registered output next state; wr_data holds when nothing is granted
   always_comb begin
      gnt_d      = '0;
      wr_en_d    = '0;
      wr_data_d  = wr_data_q;
      addr_err_d = 1'b0;
      if (grant) begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            gnt_d[i] = (32'(win) == i);
         end
         for (int r = 0; r < int'(NUM_REG); r++) begin
            wr_en_d[r] = addr_ok && (32'(win_addr) == r);
         end
         wr_data_d  = bus.req_data[32'(win)*DATA_W +: DATA_W];
         addr_err_d = !addr_ok;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         gnt_q       <= '0;
         wr_en_q     <= '0;
         wr_data_q   <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         gnt_q       <= gnt_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.owner_vld = (state_q == StOwn);
   assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: 3 requesters, 6-entry bank, bursts of up to 4.
module tb_reg_write_arbiter;

   localparam int unsigned NUM_REQ   = 3;
   localparam int unsigned NUM_REG   = 6;
   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned DATA_W    = 20;
   localparam int unsigned MAX_BURST = 4;

   logic clk;
   logic rst_n;
   int   nvec;
   int   nerr;

   reg_write_arbiter_if #(
      .NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) bus ();

   reg_write_arbiter #(
      .NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the register bank capturing on the negedge
   logic [DATA_W-1:0] bank [NUM_REG];
   always @(negedge clk) begin
      for (int r = 0; r < int'(NUM_REG); r++) begin
         if (bus.wr_en[r]) bank[r] <= bus.wr_data;
      end
   end

   task automatic set_req(input int i, input logic v, input logic l,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req_valid[i]               = v;
      bus.req_lock[i]                = l;
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
      bus.req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic clear_reqs;
      bus.req_valid = '0;
      bus.req_lock  = '0;
      bus.req_addr  = 'x;
      bus.req_data  = 'x;
   endtask

   task automatic do_reset;
      clear_reqs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      do_reset();
      set_req(0, 1'b1, 1'b0, 3'd2, 20'h11111);
      set_req(1, 1'b1, 1'b0, 3'd4, 20'h22222);
      set_req(2, 1'b1, 1'b0, 3'd1, 20'h33333);
      step();
      step();
      rst_n = 1'b0;
      #1;
      nvec++;
      if (bus.gnt !== 3'b000) begin
         nerr++; $display("FAIL reset_gnt got %b want 000", bus.gnt);
      end
      nvec++;
      if (bus.wr_en !== 6'b0) begin
         nerr++; $display("FAIL reset_wr_en got %b want 000000", bus.wr_en);
      end
      nvec++;
      if (bus.wr_data !== 20'h0) begin
         nerr++; $display("FAIL reset_wr_data got %h want 00000", bus.wr_data);
      end
      nvec++;
      if (bus.owner_vld !== 1'b0 || bus.addr_err !== 1'b0) begin
         nerr++; $display("FAIL reset_flags got %b%b want 00", bus.owner_vld, bus.addr_err);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      nvec++;
      if (bus.gnt !== 3'b001 || bus.wr_en !== 6'b000100 || bus.wr_data !== 20'h11111) begin
         nerr++;
         $display("FAIL reset_first_grant got gnt=%b wr_en=%b data=%h want 001 000100 11111",
                  bus.gnt, bus.wr_en, bus.wr_data);
      end
      clear_reqs();
      step();
   endtask

   task automatic test_round_robin;
      logic [ADDR_W-1:0] a [NUM_REQ];
      logic [DATA_W-1:0] d [NUM_REQ];
      logic [2:0]        eg;
      logic [5:0]        ew;
      a[0] = 3'd5; d[0] = 20'hABCDE;
      a[1] = 3'd1; d[1] = 20'h12345;
      a[2] = 3'd3; d[2] = 20'h0F0F0;
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, a[i], d[i]);
      for (int c = 0; c < 6; c++) begin
         step();
         eg = 3'b001 << (c % 3);
         ew = 6'b000001 << a[c % 3];
         nvec++;
         if (bus.gnt !== eg || bus.wr_en !== ew || bus.wr_data !== d[c % 3]) begin
            nerr++;
            $display("FAIL rr_cycle%0d got gnt=%b wr_en=%b data=%h want %b %b %h",
                     c, bus.gnt, bus.wr_en, bus.wr_data, eg, ew, d[c % 3]);
         end
      end
      clear_reqs();
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (bank[a[i]] !== d[i]) begin
            nerr++; $display("FAIL rr_bank reg%0d got %h want %h", a[i], bank[a[i]], d[i]);
         end
      end
      step();
   endtask

   task automatic test_lock_burst;
      logic [2:0] eg [6];
      logic       eo [6];
      eg[0] = 3'b010; eg[1] = 3'b010; eg[2] = 3'b010;
      eg[3] = 3'b010; eg[4] = 3'b100; eg[5] = 3'b001;
      eo[0] = 1'b1; eo[1] = 1'b1; eo[2] = 1'b1; eo[3] = 1'b0; eo[4] = 1'b0; eo[5] = 1'b0;
      do_reset();
      set_req(0, 1'b1, 1'b0, 3'd2, 20'h00001);
      step();
      nvec++;
      if (bus.gnt !== 3'b001) begin
         nerr++; $display("FAIL lock_pre got %b want 001", bus.gnt);
      end
      set_req(0, 1'b1, 1'b0, 3'd2, 20'h00002);
      set_req(1, 1'b1, 1'b1, 3'd4, 20'h10000);
      set_req(2, 1'b1, 1'b0, 3'd0, 20'h22222);
      for (int c = 0; c < 6; c++) begin
         step();
         nvec++;
         if (bus.gnt !== eg[c] || bus.owner_vld !== eo[c]) begin
            nerr++;
            $display("FAIL lock_cycle%0d got gnt=%b owner_vld=%b want %b %b",
                     c, bus.gnt, bus.owner_vld, eg[c], eo[c]);
         end
         if (bus.gnt[1]) set_req(1, 1'b1, 1'b1, 3'd4, 20'h10001 + 20'(c));
      end
      clear_reqs();
      step();
   endtask

   task automatic test_owner_drop;
      do_reset();
      set_req(1, 1'b1, 1'b1, 3'd2, 20'h0AAAA);
      step();
      nvec++;
      if (bus.gnt !== 3'b010 || bus.owner_vld !== 1'b1) begin
         nerr++; $display("FAIL drop_own got gnt=%b owner_vld=%b want 010 1",
                          bus.gnt, bus.owner_vld);
      end
      set_req(1, 1'b1, 1'b1, 3'd2, 20'h0BBBB);
      set_req(2, 1'b1, 1'b0, 3'd3, 20'h0CCCC);
      step();
      nvec++;
      if (bus.gnt !== 3'b010 || bus.owner_vld !== 1'b1) begin
         nerr++; $display("FAIL drop_hold got gnt=%b owner_vld=%b want 010 1",
                          bus.gnt, bus.owner_vld);
      end
      set_req(1, 1'b0, 1'b1, 'x, 'x);
      step();
      nvec++;
      if (bus.gnt !== 3'b100 || bus.owner_vld !== 1'b0 || bus.wr_data !== 20'h0CCCC) begin
         nerr++; $display("FAIL drop_switch got gnt=%b owner_vld=%b data=%h want 100 0 0cccc",
                          bus.gnt, bus.owner_vld, bus.wr_data);
      end
      clear_reqs();
      step();
   endtask

   task automatic test_addr_err;
      logic [DATA_W-1:0] snap [NUM_REG];
      do_reset();
      @(negedge clk);
      #1;
      snap = bank;
      set_req(0, 1'b1, 1'b0, 3'd7, 20'h55555);
      step();
      nvec++;
      if (bus.gnt !== 3'b001 || bus.wr_en !== 6'b0 || bus.addr_err !== 1'b1) begin
         nerr++; $display("FAIL aerr_pulse got gnt=%b wr_en=%b addr_err=%b want 001 000000 1",
                          bus.gnt, bus.wr_en, bus.addr_err);
      end
      nvec++;
      if (bus.wr_data !== 20'h55555) begin
         nerr++; $display("FAIL aerr_data got %h want 55555", bus.wr_data);
      end
      clear_reqs();
      step();
      nvec++;
      if (bus.addr_err !== 1'b0 || bus.gnt !== 3'b000) begin
         nerr++; $display("FAIL aerr_clear got addr_err=%b gnt=%b want 0 000",
                          bus.addr_err, bus.gnt);
      end
      @(negedge clk);
      #1;
      for (int r = 0; r < int'(NUM_REG); r++) begin
         nvec++;
         if (bank[r] !== snap[r]) begin
            nerr++; $display("FAIL aerr_bank reg%0d got %h want %h", r, bank[r], snap[r]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] ew;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         set_req(2, 1'b1, 1'b0, 3'(c), 20'h30000 + 20'(c));
         step();
         ew = 6'b000001 << c;
         nvec++;
         if (bus.gnt !== 3'b100 || bus.wr_en !== ew || bus.wr_data !== 20'h30000 + 20'(c)) begin
            nerr++;
            $display("FAIL b2b_cycle%0d got gnt=%b wr_en=%b data=%h want 100 %b %h",
                     c, bus.gnt, bus.wr_en, bus.wr_data, ew, 20'h30000 + 20'(c));
         end
      end
      set_req(0, 1'b1, 1'b0, 3'd0, 20'h00077);
      set_req(1, 1'b1, 1'b0, 3'd1, 20'h00088);
      set_req(2, 1'b1, 1'b0, 3'd2, 20'h00099);
      step();
      nvec++;
      if (bus.gnt !== 3'b001) begin
         nerr++; $display("FAIL b2b_wrap got gnt=%b want 001", bus.gnt);
      end
      clear_reqs();
      step();
   endtask

   initial begin
      nvec  = 0;
      nerr  = 0;
      rst_n = 1'b0;
      clear_reqs();
      test_reset();
      test_round_robin();
      test_lock_burst();
      test_owner_drop();
      test_addr_err();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
